// File: rtl/led7seg_74hc595_receiver.sv
`timescale 1ns/1ps
// Receive-side model of a 74HC595-driven 7-segment display: deserialises
// {segment, select} words from sclk/rclk/dio and rebuilds the digit frame.
module led7seg_74hc595_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int DIG_NUM     = 8,
  parameter int SEG_NUM     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         rclk,
  input  logic                         dio,
  output logic [SEG_NUM+DIG_NUM-1:0]   word,
  output logic                         word_vld,
  output logic [$clog2(DIG_NUM)-1:0]   dig_idx,
  output logic [DIG_NUM*SEG_NUM-1:0]   seg_frame,
  output logic                         frame_vld,
  output logic                         err_onehot,
  output logic                         err_bitcnt
);

  localparam int WORD_W = SEG_NUM + DIG_NUM;
  localparam int IDX_W  = $clog2(DIG_NUM);

  logic [SYNC_STAGES-1:0] sclk_sync_q, rclk_sync_q, dio_sync_q;
  logic                   sclk_prev_q, rclk_prev_q;
  logic                   sclk_s, rclk_s, dio_s;
  logic                   sclk_rise, rclk_rise;

  logic [WORD_W-1:0]          shift_reg_q, shift_reg_d;
  logic [4:0]                 bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]          word_q, word_d;
  logic                       word_vld_q, word_vld_d;
  logic                       err_onehot_q, err_onehot_d;
  logic                       err_bitcnt_q, err_bitcnt_d;
  logic [IDX_W-1:0]           dig_idx_q, dig_idx_d;
  logic [DIG_NUM*SEG_NUM-1:0] seg_frame_q, seg_frame_d;
  logic [DIG_NUM-1:0]         mask_q, mask_d;
  logic                       frame_vld_q, frame_vld_d;

  logic [DIG_NUM-1:0] sel;
  logic [IDX_W:0]     sel_ones;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_onehot;
  logic [DIG_NUM-1:0] mask_set;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign rclk_s    = rclk_sync_q[SYNC_STAGES-1];
  assign dio_s     = dio_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign rclk_rise = rclk_s & ~rclk_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      rclk_sync_q <= '0;
      dio_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      rclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      rclk_sync_q <= {rclk_sync_q[SYNC_STAGES-2:0], rclk};
      dio_sync_q  <= {dio_sync_q[SYNC_STAGES-2:0], dio};
      sclk_prev_q <= sclk_s;
      rclk_prev_q <= rclk_s;
    end
  end

  // Decode looks at the pre-shift register, so a latch coinciding with a
  // shift sees the word as it stood before that shift (595 behaviour).
  always_comb begin
    sel      = shift_reg_q[DIG_NUM-1:0];
    sel_ones = '0;
    sel_idx  = '0;
    for (int i = 0; i < DIG_NUM; i++) begin
      if (sel[i]) begin
        sel_ones = sel_ones + 1'b1;
        sel_idx  = IDX_W'(i);
      end
    end
    sel_onehot = (sel_ones == 1);
    mask_set   = mask_q | (DIG_NUM'(1) << sel_idx);
  end

  // word_vld is a one-cycle strobe with no back-pressure; err_* and the
  // decoded outputs are valid from that cycle and hold until the next strobe.
  always_comb begin
    shift_reg_d  = shift_reg_q;
    bit_cnt_d    = bit_cnt_q;
    word_d       = word_q;
    word_vld_d   = 1'b0;
    err_onehot_d = err_onehot_q;
    err_bitcnt_d = err_bitcnt_q;
    dig_idx_d    = dig_idx_q;
    seg_frame_d  = seg_frame_q;
    mask_d       = mask_q;
    frame_vld_d  = 1'b0;
    if (rclk_rise) begin
      word_d       = shift_reg_q;
      word_vld_d   = 1'b1;
      err_bitcnt_d = (bit_cnt_q != 5'(WORD_W));
      err_onehot_d = ~sel_onehot;
      bit_cnt_d    = '0;
      if (sel_onehot) begin
        dig_idx_d = sel_idx;
        seg_frame_d[sel_idx*SEG_NUM +: SEG_NUM] = shift_reg_q[WORD_W-1 -: SEG_NUM];
        if (mask_set == '1) begin
          frame_vld_d = 1'b1;
          mask_d      = '0;
        end else begin
          mask_d = mask_set;
        end
      end
    end
    if (sclk_rise) begin
      shift_reg_d = {shift_reg_q[WORD_W-2:0], dio_s};
      if (rclk_rise) begin
        bit_cnt_d = 5'd1;
      end else if (bit_cnt_q != 5'd31) begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg_q  <= '0;
      bit_cnt_q    <= '0;
      word_q       <= '0;
      word_vld_q   <= 1'b0;
      err_onehot_q <= 1'b0;
      err_bitcnt_q <= 1'b0;
      dig_idx_q    <= '0;
      seg_frame_q  <= '0;
      mask_q       <= '0;
      frame_vld_q  <= 1'b0;
    end else begin
      shift_reg_q  <= shift_reg_d;
      bit_cnt_q    <= bit_cnt_d;
      word_q       <= word_d;
      word_vld_q   <= word_vld_d;
      err_onehot_q <= err_onehot_d;
      err_bitcnt_q <= err_bitcnt_d;
      dig_idx_q    <= dig_idx_d;
      seg_frame_q  <= seg_frame_d;
      mask_q       <= mask_d;
      frame_vld_q  <= frame_vld_d;
    end
  end

  assign word       = word_q;
  assign word_vld   = word_vld_q;
  assign dig_idx    = dig_idx_q;
  assign seg_frame  = seg_frame_q;
  assign frame_vld  = frame_vld_q;
  assign err_onehot = err_onehot_q;
  assign err_bitcnt = err_bitcnt_q;

endmodule

// File: tb/tb_led7seg_74hc595_receiver.sv
`timescale 1ns/1ps
// Bench for led7seg_74hc595_receiver: directed vector table, corner-case
// sequences and random words checked against a behavioural display model.
module tb_led7seg_74hc595_receiver;

  logic        clk = 1'b0;
  logic        rst, sclk, rclk, dio;
  logic [15:0] word;
  logic        word_vld;
  logic [2:0]  dig_idx;
  logic [63:0] seg_frame;
  logic        frame_vld, err_onehot, err_bitcnt;

  int checks = 0;
  int errors = 0;

  // Expected record: {frame_vld, err_onehot, err_bitcnt, dig_idx, seg_frame, word}
  logic [85:0] exp_q[$];
  logic [85:0] mon_e;

  // Behavioural display model
  logic [15:0] m_sr;
  int          m_cnt;
  logic [7:0]  m_frame[8];
  logic [2:0]  m_idx;
  logic [7:0]  m_mask;

  // Values seen on the word_vld cycle by wait_vld
  logic [15:0] cap_word;
  logic        cap_eo, cap_eb, cap_fv;
  logic [2:0]  cap_idx;
  logic [63:0] cap_frame;

  typedef struct {
    logic [31:0] w;
    int          n;
    logic [15:0] ew;
    logic        eo;
    logic        eb;
    logic        fv;
    logic [2:0]  ei;
    logic [7:0]  es;
  } vec_t;
  vec_t vecs[13];

  led7seg_74hc595_receiver #(.SYNC_STAGES(2), .DIG_NUM(8), .SEG_NUM(8)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .rclk(rclk), .dio(dio),
    .word(word), .word_vld(word_vld), .dig_idx(dig_idx), .seg_frame(seg_frame),
    .frame_vld(frame_vld), .err_onehot(err_onehot), .err_bitcnt(err_bitcnt)
  );

  // Clock / reset block
  always #4 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_frame();
    logic [63:0] f;
    f = '0;
    for (int d = 0; d < 8; d++) f[d*8 +: 8] = m_frame[d];
    return f;
  endfunction

  task automatic model_reset();
    m_sr = '0; m_cnt = 0; m_idx = '0; m_mask = '0;
    for (int d = 0; d < 8; d++) m_frame[d] = '0;
  endtask

  task automatic model_shift(input logic b);
    m_sr  = 16'((int'(m_sr) * 2 + int'(b)) % 65536);
    m_cnt = (m_cnt < 31) ? m_cnt + 1 : 31;
  endtask

  task automatic model_latch();
    int ones = 0;
    int pos = 0;
    logic eo, eb, fv;
    eb = (m_cnt != 16);
    for (int p = 0; p < 8; p++) if (m_sr[p]) begin ones++; pos = p; end
    eo = (ones != 1);
    fv = 1'b0;
    if (!eo) begin
      m_idx = 3'(pos);
      m_frame[pos] = m_sr[15:8];
      m_mask[pos] = 1'b1;
      if (m_mask == 8'hFF) begin
        fv = 1'b1;
        m_mask = '0;
      end
    end
    m_cnt = 0;
    exp_q.push_back({fv, eo, eb, m_idx, pack_frame(), m_sr});
  endtask

  // Scoreboard: every word_vld strobe must match the next expected record
  always @(negedge clk) begin
    if (word_vld) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word_vld: got word %0h expected no strobe", word);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_word", 64'(word), 64'(mon_e[15:0]));
        check("sb_seg_frame", seg_frame, mon_e[79:16]);
        check("sb_dig_idx", 64'(dig_idx), 64'(mon_e[82:80]));
        check("sb_err_bitcnt", 64'(err_bitcnt), 64'(mon_e[83]));
        check("sb_err_onehot", 64'(err_onehot), 64'(mon_e[84]));
        check("sb_frame_vld", 64'(frame_vld), 64'(mon_e[85]));
      end
    end else if (frame_vld) begin
      checks++; errors++;
      $display("FAIL stray_frame_vld: got 1 expected 0 without word_vld");
    end
  end

  // Driver tasks
  task automatic send_bit(input logic b);
    dio = b;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    model_shift(b);
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic wait_vld(input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (word_vld) begin
        got = 1'b1;
        cap_word = word; cap_eo = err_onehot; cap_eb = err_bitcnt;
        cap_fv = frame_vld; cap_idx = dig_idx; cap_frame = seg_frame;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: got no word_vld expected one within 10 cycles", name);
    end
  endtask

  task automatic do_latch(input string name);
    repeat (4) @(negedge clk);
    model_latch();
    rclk = 1'b1;
    wait_vld(name);
    repeat (3) @(negedge clk);
    rclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_word"}, 64'(word), 64'd0);
    check({name, "_word_vld"}, 64'(word_vld), 64'd0);
    check({name, "_dig_idx"}, 64'(dig_idx), 64'd0);
    check({name, "_seg_frame"}, seg_frame, 64'd0);
    check({name, "_frame_vld"}, 64'(frame_vld), 64'd0);
    check({name, "_err_onehot"}, 64'(err_onehot), 64'd0);
    check({name, "_err_bitcnt"}, 64'(err_bitcnt), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{32'hC001, 16, 16'hC001, 1'b0, 1'b0, 1'b0, 3'd0, 8'hC0};
    vecs[1]  = '{32'hF901, 16, 16'hF901, 1'b0, 1'b0, 1'b0, 3'd0, 8'hF9};
    vecs[2]  = '{32'hA402, 16, 16'hA402, 1'b0, 1'b0, 1'b0, 3'd1, 8'hA4};
    vecs[3]  = '{32'hB004, 16, 16'hB004, 1'b0, 1'b0, 1'b0, 3'd2, 8'hB0};
    vecs[4]  = '{32'h9908, 16, 16'h9908, 1'b0, 1'b0, 1'b0, 3'd3, 8'h99};
    vecs[5]  = '{32'h9210, 16, 16'h9210, 1'b0, 1'b0, 1'b0, 3'd4, 8'h92};
    vecs[6]  = '{32'h8220, 16, 16'h8220, 1'b0, 1'b0, 1'b0, 3'd5, 8'h82};
    vecs[7]  = '{32'hF840, 16, 16'hF840, 1'b0, 1'b0, 1'b0, 3'd6, 8'hF8};
    vecs[8]  = '{32'h8080, 16, 16'h8080, 1'b0, 1'b0, 1'b1, 3'd7, 8'h80};
    vecs[9]  = '{32'h4F08, 16, 16'h4F08, 1'b0, 1'b0, 1'b0, 3'd3, 8'h4F};
    vecs[10] = '{32'h9203, 16, 16'h9203, 1'b1, 1'b0, 1'b0, 3'd3, 8'h4F};
    vecs[11] = '{32'h0401, 15, 16'h8401, 1'b0, 1'b1, 1'b0, 3'd0, 8'h84};
    vecs[12] = '{32'h8080, 16, 16'h8080, 1'b0, 1'b0, 1'b0, 3'd7, 8'h80};

    rst = 1'b1; sclk = 1'b0; rclk = 1'b0; dio = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Directed table: single word, full frame, bad select, short word
    for (int v = 0; v < 13; v++) begin
      send_word(vecs[v].w, vecs[v].n);
      do_latch("vec");
      check("vec_word", 64'(cap_word), 64'(vecs[v].ew));
      check("vec_err_onehot", 64'(cap_eo), 64'(vecs[v].eo));
      check("vec_err_bitcnt", 64'(cap_eb), 64'(vecs[v].eb));
      check("vec_frame_vld", 64'(cap_fv), 64'(vecs[v].fv));
      check("vec_dig_idx", 64'(cap_idx), 64'(vecs[v].ei));
      check("vec_seg_slot", 64'(cap_frame[vecs[v].ei*8 +: 8]), 64'(vecs[v].es));
    end

    // sclk and rclk rise together: latch sees the pre-shift word
    send_word(32'hA404, 16);
    dio = 1'b1;
    repeat (4) @(negedge clk);
    model_latch();
    model_shift(1'b1);
    sclk = 1'b1; rclk = 1'b1;
    wait_vld("simul");
    check("simul_word", 64'(cap_word), 64'hA404);
    check("simul_err_bitcnt", 64'(cap_eb), 64'd0);
    check("simul_dig_idx", 64'(cap_idx), 64'd2);
    repeat (3) @(negedge clk);
    sclk = 1'b0; rclk = 1'b0;
    repeat (4) @(negedge clk);
    // one bit already counted, so 15 more make a complete word
    send_word(32'h0001, 15);
    do_latch("simul_next");
    check("simul_next_word", 64'(cap_word), 64'h8001);
    check("simul_next_err_bitcnt", 64'(cap_eb), 64'd0);

    // Reset in the middle of a word
    send_word(32'h005A, 7);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    model_reset();
    check("midrst_pending", 64'(exp_q.size()), 64'd0);
    repeat (4) @(negedge clk);
    send_word(32'hB001, 16);
    do_latch("post_rst");
    check("post_rst_word", 64'(cap_word), 64'hB001);
    check("post_rst_err_bitcnt", 64'(cap_eb), 64'd0);
    check("post_rst_err_onehot", 64'(cap_eo), 64'd0);
    check("post_rst_seg_frame", cap_frame, 64'h0000_0000_0000_00B0);

    // Random words, mostly one-hot selects, occasionally wrong bit counts
    for (int r = 0; r < 40; r++) begin
      logic [7:0]  rsel, rseg;
      logic [31:0] rw;
      int          rn;
      rsel = ($urandom_range(0, 3) != 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      rseg = 8'($urandom);
      rn   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 20)) : 16;
      rw   = {16'($urandom), rseg, rsel};
      send_word(rw, rn);
      do_latch("rand");
    end

    repeat (10) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led7seg_74hc595_receiver.md
Name: led7seg_74hc595_receiver

Overview:
- Receive-side counterpart of the 74HC595 LED7-seg controller.
- Samples the serial sclk/rclk/dio lines and deserialises each 16-bit {segment, digit-select} word.
- Checks each word and rebuilds the 8-digit segment frame the board would display.
- Used as an on-chip display monitor/loopback checker and as a bench model of the display hardware.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per serial input (min 2).
- DIG_NUM, 8, number of digits; fixed width of the digit-select byte.
- SEG_NUM, 8, segment bits per digit.

Ports:
- clk  input  1  system clock (125 MHz)
- rst  input  1  synchronous, active-high reset
- sclk  input  1  serial shift clock from controller, asynchronous to clk
- rclk  input  1  storage/latch clock from controller, asynchronous to clk
- dio  input  1  serial data from controller
- word  output  16  last latched word: [15:8] segment, [7:0] digit select
- word_vld  output  1  one-cycle pulse when word updates
- dig_idx  output  3  index of the one-hot select bit of the last good word
- seg_frame  output  64  digit n segments at [n*8+7 : n*8]
- frame_vld  output  1  one-cycle pulse when all 8 digits are refreshed
- err_onehot  output  1  valid with word_vld: select byte not exactly one-hot
- err_bitcnt  output  1  valid with word_vld: shift count since last latch != 16

Behaviour:
- Synchronisation and edge detection
  - sclk, rclk and dio each pass through a SYNC_STAGES-deep flop chain; all flops reset to 0.
  - Rising edge is detected as synced value 1 while the previous synced value was 0.
  - Input high/low time must each be >= SYNC_STAGES+1 clk cycles; narrower pulses are undefined.
- Shift on sclk rise
  - shift_reg <= {shift_reg[14:0], dio_sync}. The first bit shifted ends at word[15] after 16 shifts.
  - bit_cnt (5-bit) increments and saturates at 31.
- Latch on rclk rise
  - Next cycle: word <= shift_reg; word_vld = 1 for exactly one cycle.
  - err_bitcnt = (bit_cnt != 16) and err_onehot are registered alongside word.
  - bit_cnt clears to 0.
- Simultaneous sclk and rclk rise in the same cycle (matches 595 hardware)
  - The latch takes the pre-shift shift_reg and the pre-shift bit_cnt check.
  - The shift still occurs; bit_cnt becomes 1.
- Decode (same cycle as the word update)
  - If select is one-hot: dig_idx <= bit position and seg_frame[dig_idx] <= word[15:8].
  - Otherwise (0x00 or multiple bits set): err_onehot = 1; seg_frame and dig_idx are unchanged.
  - err_bitcnt does not block the decode.
- Frame tracking
  - An 8-bit written_mask sets the bit of each successfully decoded digit.
  - When the mask becomes 0xFF: frame_vld pulses one cycle in the same cycle as that seg_frame update, and the mask clears.
  - Rewriting a digit already in the mask does not pulse frame_vld.
- Latency: sclk/rclk pin edge to state update is SYNC_STAGES+1 cycles; word_vld follows one cycle after the rclk edge is detected.
- Reset (synchronous, clears all state regardless of in-progress activity)
  - word = 0, word_vld = 0, dig_idx = 0, seg_frame = 0, frame_vld = 0, err_onehot = 0, err_bitcnt = 0.
  - shift_reg = 0, bit_cnt = 0, written_mask = 0, synchronisers = 0.
  - Reset mid-shift discards the partial word. No spurious edge is detected on the first cycle after reset: synced lines are 0, so only a genuine rising edge triggers.

Test Plan:
1. Shift 16 bits of 0xC001 MSB-first, then pulse rclk -> word=0xC001, one word_vld pulse, dig_idx=0, seg_frame[7:0]=0xC0, err_onehot=0, err_bitcnt=0.
2. Send eight words with selects 0x01,0x02,...,0x80 and segments 0xF9,0xA4,... -> each byte lands in the matching seg_frame slot; frame_vld pulses once, coincident with the 8th word_vld; mask clears; a 9th word to digit 3 gives no frame_vld.
3. Send word 0x9203 (two select bits) -> word_vld with err_onehot=1; seg_frame and dig_idx unchanged from previous values.
4. Shift only 15 bits, then rclk -> err_bitcnt=1 and word=shift_reg contents. Next 16-bit word 0x8080 -> err_bitcnt=0, seg_frame[63:56]=0x80.
5. Drive sclk and rclk rising in the same clk cycle after 16 valid bits of 0xA404 -> word=0xA404 (pre-shift value); bit_cnt=1 afterwards.
6. Assert rst after 7 bits of a shift -> all outputs 0 next cycle, no word_vld. A subsequent full 0xB001 word decodes cleanly with err_bitcnt=0.
